morse_key_classifier: RTL and testbench



---
 rtl/morse_key_classifier.sv | 183 ++++++++++++++++++
 tb/tb_morse_key_classifier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_classifier.sv
// morse_key_classifier: times key marks and spaces in Morse units and turns
// them into one-cycle dot / dash / letter-gap / word-gap strobes, plus a
// stuck-key error strobe.
// Optional build macro: MORSE_KEY_SYNC_EN inserts a two-flop synchronizer on
// the raw key, which delays every strobe by two further cycles.
module morse_key_classifier #(
  parameter int UNIT  = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic dot,
  output logic dash,
  output logic lg,
  output logic wg,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_LG    = CNT_W'(2 * UNIT);
  localparam logic [CNT_W-1:0] T_WG    = CNT_W'(5 * UNIT);
  localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(8 * UNIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_STUCK
  } state_t;

  logic key_s;

`ifdef MORSE_KEY_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw key into the two-stage synchronizer.
  always_comb begin
    sync_d = {sync_q[0], key};
  end

  // Synchronizer flops, cleared on reset so a held key reads low until it
  // has propagated through both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign key_s = sync_q[1];
`else
  assign key_s = key;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sym_pend_q, sym_pend_d;
  logic             word_pend_q, word_pend_d;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             lg_q, lg_d;
  logic             wg_q, wg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_inc;

  // Next state, duration counting, pending flags and strobe decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_pend_d  = sym_pend_q;
    word_pend_d = word_pend_q;
    dot_d       = 1'b0;
    dash_d      = 1'b0;
    lg_d        = 1'b0;
    wg_d        = 1'b0;
    err_d       = 1'b0;
    // Count of the current level including this sample, saturating.
    cnt_inc     = (cnt_q >= T_MAX) ? T_MAX : (cnt_q + CNT_ONE);

    case (state_q)
      S_IDLE: begin
        if (key_s) begin
          state_d = S_MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_MARK: begin
        if (key_s) begin
          cnt_d = cnt_inc;
          if (cnt_inc == T_MAX) begin
            err_d   = 1'b1;
            state_d = S_STUCK;
          end
        end else begin
          // cnt_q still holds the length of the mark that just ended.
          if (cnt_q < T_LG) begin
            dot_d = 1'b1;
          end else begin
            dash_d = 1'b1;
          end
          sym_pend_d = 1'b1;
          state_d    = S_SPACE;
          cnt_d      = CNT_ONE;
        end
      end

      S_STUCK: begin
        // A stuck mark is discarded; only its release restarts gap timing.
        if (!key_s) begin
          state_d = S_SPACE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_SPACE: begin
        // A new press always wins over a gap strobe due on the same sample.
        if (key_s) begin
          state_d = S_MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if ((cnt_inc == T_LG) && sym_pend_q) begin
            lg_d        = 1'b1;
            sym_pend_d  = 1'b0;
            word_pend_d = 1'b1;
          end
          if (cnt_inc == T_WG) begin
            state_d = S_IDLE;
            if (word_pend_q) begin
              wg_d        = 1'b1;
              word_pend_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, flags and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sym_pend_q  <= 1'b0;
      word_pend_q <= 1'b0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      lg_q        <= 1'b0;
      wg_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_pend_q  <= sym_pend_d;
      word_pend_q <= word_pend_d;
      dot_q       <= dot_d;
      dash_q      <= dash_d;
      lg_q        <= lg_d;
      wg_q        <= wg_d;
      err_q       <= err_d;
    end
  end

  assign dot  = dot_q;
  assign dash = dash_q;
  assign lg   = lg_q;
  assign wg   = wg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// tb_morse_key_classifier: directed Morse scenarios with literal timing pins,
// followed by randomized key runs, all checked every cycle against a run-length
// model of the classifier (UNIT=4, base build).
module tb_morse_key_classifier;

  localparam int UNIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b0;
  logic dot, dash, lg, wg, err;

  morse_key_classifier #(.UNIT(UNIT), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .dot  (dot),
    .dash (dash),
    .lg   (lg),
    .wg   (wg),
    .err  (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: lengths of the current high/low runs plus the two
  // pending flags; expected strobes as {dot,dash,lg,wg,err}.
  int         hi_run = 0;
  int         lo_run = 0;
  bit         m_sym  = 1'b0;
  bit         m_word = 1'b0;
  logic [4:0] exp_v  = 5'b0;

  int n_dot = 0, n_dash = 0, n_lg = 0, n_wg = 0, n_err = 0;
  int l_dot = -1, l_dash = -1, l_lg = -1, l_wg = -1, l_err = -1;
  int b_dot, b_dash, b_lg, b_wg, b_err;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s at sample %0d: got %0d, expected %0d", name, cyc, got, want);
  endtask

  // Model evaluation on each sample edge.
  always @(posedge clk) begin
    cyc++;
    exp_v = 5'b0;
    if (rst) begin
      hi_run = 0;
      lo_run = 0;
      m_sym  = 1'b0;
      m_word = 1'b0;
    end else if (key) begin
      lo_run = 0;
      hi_run++;
      if (hi_run == 8 * UNIT) exp_v[0] = 1'b1;
    end else begin
      if (hi_run > 0 && hi_run < 8 * UNIT) begin
        if (hi_run < 2 * UNIT) exp_v[4] = 1'b1;
        else exp_v[3] = 1'b1;
        m_sym = 1'b1;
      end
      hi_run = 0;
      lo_run++;
      if (lo_run == 2 * UNIT && m_sym) begin
        exp_v[2] = 1'b1;
        m_sym    = 1'b0;
        m_word   = 1'b1;
      end
      if (lo_run == 5 * UNIT && m_word) begin
        exp_v[1] = 1'b1;
        m_word   = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, and strobe bookkeeping.
  always @(posedge clk) begin
    #1;
    check("strobes", int'({dot, dash, lg, wg, err}), int'(exp_v));
    if (dot)  begin n_dot++;  l_dot  = cyc; end
    if (dash) begin n_dash++; l_dash = cyc; end
    if (lg)   begin n_lg++;   l_lg   = cyc; end
    if (wg)   begin n_wg++;   l_wg   = cyc; end
    if (err)  begin n_err++;  l_err  = cyc; end
  end

  task automatic step(input bit k, input bit r);
    @(negedge clk);
    key = k;
    rst = r;
  endtask

  task automatic run(input bit k, input int n);
    repeat (n) step(k, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic snap();
    b_dot = n_dot; b_dash = n_dash; b_lg = n_lg; b_wg = n_wg; b_err = n_err;
  endtask

  task automatic check_deltas(input string tag, input int d_dot, input int d_dash,
                              input int d_lg, input int d_wg, input int d_err);
    check({tag, " dot count"},  n_dot - b_dot, d_dot);
    check({tag, " dash count"}, n_dash - b_dash, d_dash);
    check({tag, " lg count"},   n_lg - b_lg, d_lg);
    check({tag, " wg count"},   n_wg - b_wg, d_wg);
    check({tag, " err count"},  n_err - b_err, d_err);
    $display("scenario %s: dot=%0d dash=%0d lg=%0d wg=%0d err=%0d", tag,
             n_dot - b_dot, n_dash - b_dash, n_lg - b_lg, n_wg - b_wg, n_err - b_err);
  endtask

  int fall;
  int start;
  int lens[3] = '{7, 8, 31};

  initial begin
    // Reset state.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset outputs", int'({dot, dash, lg, wg, err}), 0);

    // Single dot followed by a full word gap.
    do_reset(); snap();
    run(1'b1, 4);
    step(1'b0, 1'b0);
    fall = cyc + 1;
    run(1'b0, 26);
    check("dot timing", l_dot, fall);
    check("lg timing", l_lg, fall + 2 * UNIT - 1);
    check("wg timing", l_wg, fall + 5 * UNIT - 1);
    check_deltas("dot_word", 1, 0, 1, 1, 0);

    // Dash, short intra-letter gap, dot, then only a letter gap.
    do_reset(); snap();
    run(1'b1, 12); run(1'b0, 3); run(1'b1, 4); run(1'b0, 12);
    check("dash before dot", int'(l_dash < l_dot), 1);
    check_deltas("dash_dot", 1, 1, 1, 0, 0);

    // Mark-length boundaries.
    foreach (lens[i]) begin
      do_reset(); snap();
      run(1'b1, lens[i]); run(1'b0, 25);
      check_deltas($sformatf("mark_%0d", lens[i]),
                   (lens[i] < 2 * UNIT) ? 1 : 0, (lens[i] < 2 * UNIT) ? 0 : 1, 1, 1, 0);
    end

    // Stuck key with no prior symbol.
    do_reset(); snap();
    step(1'b1, 1'b0);
    start = cyc + 1;
    run(1'b1, 39); run(1'b0, 25);
    check("err timing", l_err, start + 8 * UNIT - 1);
    check_deltas("stuck", 0, 0, 0, 0, 1);

    // Reset mid-mark with the key released during reset.
    do_reset(); snap();
    run(1'b1, 5);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    run(1'b0, 3);
    check_deltas("reset_mid_mark", 0, 0, 0, 0, 0);
    snap();
    run(1'b1, 4); run(1'b0, 25);
    check_deltas("after_reset", 1, 0, 1, 1, 0);

    // Press on the letter-gap threshold sample; new mark of 7 must be a dot.
    do_reset(); snap();
    run(1'b1, 4); run(1'b0, 2 * UNIT - 1);
    step(1'b1, 1'b0);
    start = cyc + 1;
    run(1'b1, 6); run(1'b0, 25);
    check("lg after repress", l_lg, start + 7 + 2 * UNIT - 1);
    check_deltas("repress_at_lg", 2, 0, 1, 1, 0);

    // Randomized runs of key levels with occasional resets.
    begin
      bit lvl = 1'b0;
      for (int r = 0; r < 400; r++) begin
        int u, len;
        lvl = ~lvl;
        u = $urandom_range(0, 9);
        if (u < 6) len = $urandom_range(1, 10);
        else if (u < 9) len = $urandom_range(10, 26);
        else len = $urandom_range(28, 40);
        for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 199) == 0));
      end
    end
    run(1'b0, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
